lpf_decimator: RTL
==================

Name: lpf_decimator

Overview:
- Downstream neighbour of the FIR low-pass stage. Consumes the filter's sparse output stream (sample plus one-cycle valid strobe, no back-pressure).
- Keeps every Factor-th sample, phase-aligned to a frame sync. Buffers kept samples in a small FIFO.
- Presents them to the compression stage over a valid/ready handshake.
- Reports FIFO fill level and a sticky overflow flag.

Parameters:
- DataBits, 10, sample width. Two's complement; passed through unmodified.
- Factor, 4, decimation factor. Must be >= 1; Factor = 1 is pass-through.
- Depth, 8, FIFO entries. Must be a power of two and >= 2.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- data_i  in  DataBits  filtered sample from the LPF.
- valid_i  in  1  one-cycle strobe; data_i is valid in that cycle.
- sync_i  in  1  frame start; re-aligns the decimation phase.
- ovf_clear_i  in  1  clears the sticky overflow flag.
- data_o  out  DataBits  FIFO head sample.
- valid_o  out  1  FIFO not empty.
- ready_i  in  1  downstream accepts data_o.
- level_o  out  $clog2(Depth)+1  number of FIFO entries.
- overflow_o  out  1  sticky: a kept sample was dropped.

Behaviour:
- Reset (rst_i high, asynchronous, any state):
  - phase counter = 0; FIFO empty with both pointers = 0.
  - data_o = 0, valid_o = 0, level_o = 0, overflow_o = 0.
  - Takes effect immediately, including mid-burst. FIFO contents are discarded.
- Phase counter, range 0..Factor-1:
  - Advances on each valid_i; wraps at Factor-1 to 0.
  - keep = valid_i && (phase_q == 0 || sync_i).
- sync_i rules:
  - sync_i with valid_i: that sample is kept; phase_d = 1 mod Factor.
  - sync_i without valid_i: phase_d = 0, so the next valid sample is kept.
  - Factor = 1: every valid sample is kept; sync_i has no effect.
- Pop: pop = valid_o && ready_i. Head advances on the next edge.
- Push:
  - push = keep && (level_q < Depth || pop). A full FIFO with a simultaneous pop accepts the new sample.
  - keep while full and no pop: the sample is dropped and overflow_o is set on the next edge.
- overflow_o:
  - Cleared by ovf_clear_i.
  - If a set event and ovf_clear_i coincide, set wins.
- Latency and ordering:
  - A kept sample appears on data_o with valid_o high one cycle after its valid_i cycle, if the FIFO was empty.
  - First-word fall-through; order is preserved.
- level_o:
  - Updates on the edge: +1 push only, -1 pop only, unchanged for both or neither.
  - Never exceeds Depth.
- Pointers: Depth-wrapping binary counters with an extra MSB for full/empty distinction.
- Handshake (AXI-stream style):
  - data_o is stable while valid_o && !ready_i.
  - valid_o never drops without a pop.
- Storage: registers or distributed RAM with asynchronous read at the read pointer. data_o = mem[rd_ptr] when valid_o is high, else 0.
- Parameter checks: elaboration-time assertions on Factor >= 1 and on Depth being a power of two and >= 2.

Decomposition:
- Shared package lpf_chain_pkg holds:
  - the default sample width constant (10) and sample_t typedef, shared with the LPF;
  - the default decimation factor;
  - the default FIFO depth.
- Sub-module sample_fifo (parameters DataWidth, Depth; ports push/pop/data/level/full/empty) holds storage and pointers.
- lpf_decimator contains the phase counter, keep logic, overflow flag and handshake glue.

Test Plan:
- Factor=4, ready_i=1; valid_i strobed every 3 cycles with data 1..16 -> data_o = 1, 5, 9, 13, each one cycle after its input strobe; overflow_o = 0.
- Factor=4; stream 1..6, then sync_i with sample 7, then 8..12 -> kept samples 1, 5, 7, 11.
- Factor=1, Depth=4, ready_i=0; push -1, -2, 3, 4, 5 -> level_o = 4, overflow_o = 1. Then ready_i=1 -> outputs -1, -2, 3, 4 (0x3FF, 0x3FE, 3, 4); sample 5 is lost.
- Depth=4 full, ready_i=1, and a kept sample 9 arrives in the same cycle as the pop -> level_o stays 4, overflow_o = 0, sample 9 is emitted last.
- overflow_o = 1; ovf_clear_i pulsed -> overflow_o = 0. Next, a pulse coinciding with a drop -> overflow_o stays 1.
- rst_i asserted asynchronously mid-stream with 3 entries -> valid_o, level_o and data_o are 0 immediately. After release, the first valid sample is kept (phase 0).

Source files
------------

// File: rtl/lpf_chain_pkg.sv
// Constants shared along the LPF -> decimator -> compression chain.
// Sample format is two's complement and passes through the decimator unmodified.
package lpf_chain_pkg;

   localparam int unsigned SampleBits  = 10;
   typedef logic [SampleBits-1:0] sample_t;

   localparam int unsigned DecimFactor = 4;
   localparam int unsigned FifoDepth   = 8;

endpackage

// File: rtl/sample_fifo.sv
// First-word fall-through sample FIFO with register storage and asynchronous read.
// Pointers carry one extra MSB so full and empty are distinguishable.
module sample_fifo
   import lpf_chain_pkg::*;
#(
   parameter int unsigned DataWidth = SampleBits,
   parameter int unsigned Depth     = FifoDepth
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [DataWidth-1:0]     data_i,
   output logic [DataWidth-1:0]     data_o,
   output logic [$clog2(Depth):0]   level_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int unsigned AddrBits  = $clog2(Depth);
   localparam int unsigned LevelBits = AddrBits + 1;
   localparam logic [AddrBits:0] DepthLevel = LevelBits'(Depth);

   if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : gen_depth_check
      $error("sample_fifo: Depth must be a power of two and >= 2");
   end

   logic [AddrBits:0]    wr_ptr_q, wr_ptr_d;
   logic [AddrBits:0]    rd_ptr_q, rd_ptr_d;
   logic [DataWidth-1:0] mem_q [Depth];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_i) wr_ptr_d = wr_ptr_q + LevelBits'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + LevelBits'(1);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Full-with-pop writes the slot being vacated; the read is async so the old head is seen first.
   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_ptr_q[AddrBits-1:0]] <= data_i;
   end

   assign level_o = wr_ptr_q - rd_ptr_q;
   assign full_o  = (level_o == DepthLevel);
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q[AddrBits-1:0]];

endmodule

// File: rtl/lpf_decimator.sv
// Keeps every Factor-th LPF sample (re-aligned by sync_i), buffers kept samples in a FIFO
// and offers them downstream over valid/ready with a sticky overflow flag.
module lpf_decimator
   import lpf_chain_pkg::*;
#(
   parameter int unsigned DataBits = SampleBits,
   parameter int unsigned Factor   = DecimFactor,
   parameter int unsigned Depth    = FifoDepth
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [DataBits-1:0]     data_i,
   input  logic                    valid_i,
   input  logic                    sync_i,
   input  logic                    ovf_clear_i,
   output logic [DataBits-1:0]     data_o,
   output logic                    valid_o,
   input  logic                    ready_i,
   output logic [$clog2(Depth):0]  level_o,
   output logic                    overflow_o
);

   localparam int unsigned PhaseBits = (Factor > 1) ? $clog2(Factor) : 1;
   localparam logic [PhaseBits-1:0] PhaseMax = PhaseBits'(Factor - 1);

   if (Factor < 1) begin : gen_factor_check
      $error("lpf_decimator: Factor must be >= 1");
   end

   logic [PhaseBits-1:0] phase_q, phase_d;
   logic                 overflow_q, overflow_d;
   logic                 keep, push, pop, fifo_full, fifo_empty;

   assign keep = valid_i && (phase_q == '0 || sync_i);
   assign pop  = valid_o && ready_i;
   assign push = keep && (!fifo_full || pop);

   always_comb begin
      phase_d = phase_q;
      if (Factor == 1) begin
         phase_d = '0;
      end else if (valid_i) begin
         if (sync_i)                phase_d = PhaseBits'(1);
         else if (phase_q == PhaseMax) phase_d = '0;
         else                       phase_d = phase_q + PhaseBits'(1);
      end else if (sync_i) begin
         phase_d = '0;
      end
   end

   // A drop in the same cycle as a clear request leaves the flag set.
   always_comb begin
      overflow_d = overflow_q;
      if (keep && fifo_full && !pop) overflow_d = 1'b1;
      else if (ovf_clear_i)          overflow_d = 1'b0;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         phase_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         phase_q    <= phase_d;
         overflow_q <= overflow_d;
      end
   end

   sample_fifo #(
      .DataWidth (DataBits),
      .Depth     (Depth)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .pop_i   (pop),
      .data_i  (data_i),
      .data_o  (data_o),
      .level_o (level_o),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign valid_o    = !fifo_empty;
   assign overflow_o = overflow_q;

endmodule
